imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that fills instruction memory and holds the CPU until a good checksum
// Stream format: count N, then N {hi, lo} word pairs, then a checksum byte making the 8-bit sum zero.
module imem_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int unsigned IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IW-1:0] TMO = IW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    acc_q, acc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    addr_q, addr_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [IW-1:0] idle_inc;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [15:0]   wr_data_q, wr_data_d;
  logic [7:0]    sum;
  logic          accept;

  assign accept   = in_valid & in_ready;
  assign sum      = acc_q + in_data;
  assign idle_inc = idle_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      addr_q    <= '0;
      idle_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      addr_q    <= addr_d;
      idle_q    <= idle_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    addr_d    = addr_q;
    idle_d    = idle_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_LEN;
          acc_d     = '0;
          cnt_d     = '0;
          addr_d    = '0;
          wr_addr_d = '0;
          idle_d    = '0;
        end
      end
      S_LEN: begin
        if (accept) begin
          cnt_d   = in_data;
          acc_d   = sum;
          state_d = (in_data == 8'd0) ? S_CHK : S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          hi_d    = in_data;
          acc_d   = sum;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          acc_d     = sum;
          wr_en_d   = 1'b1;
          wr_data_d = {hi_q, in_data};
          wr_addr_d = addr_q;
          addr_d    = addr_q + 8'd1;
          cnt_d     = cnt_q - 8'd1;
          state_d   = (cnt_q == 8'd1) ? S_CHK : S_HI;
        end
      end
      S_CHK: begin
        if (accept) begin
          acc_d   = sum;
          state_d = (sum == 8'd0) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // An acceptance on the timeout edge wins, so the check only runs on idle cycles.
    if (in_ready) begin
      if (accept) begin
        idle_d = '0;
      end else begin
        idle_d = idle_inc;
        if ((TIMEOUT_CYCLES != 0) && (idle_inc == TMO)) begin
          state_d = S_ERR;
        end
      end
    end
  end

  always_comb begin
    in_ready = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (state_q)
      S_LEN, S_HI, S_LO, S_CHK: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
      end
      S_DONE: done = 1'b1;
      S_ERR: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
      end
      default: ;
    endcase
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
